edit_cursor_ctrl: RTL and testbench

EDIT_CURSOR_CTRL -- requirements
Module: edit_cursor_ctrl

---
 rtl/rtc_edit_pkg.sv | 85 ++++++++
 rtl/bcd_step.sv | 45 ++++
 rtl/edit_cursor_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_edit_cursor_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_edit_pkg.sv
// rtl/rtc_edit_pkg.sv - shared field codes, BCD limits, FSM and button encodings
// for the RTC field editor.
package rtc_edit_pkg;

  localparam int unsigned NUM_FIELDS = 9;
  localparam logic [3:0]  IDX_FIRST  = 4'd0;
  localparam logic [3:0]  IDX_LAST   = 4'd8;

  localparam logic [6:0] CODE_NONE  = 7'h00;
  localparam logic [6:0] CODE_SEG   = 7'h21;
  localparam logic [6:0] CODE_MIN   = 7'h22;
  localparam logic [6:0] CODE_HORA  = 7'h23;
  localparam logic [6:0] CODE_DIA   = 7'h24;
  localparam logic [6:0] CODE_MES   = 7'h25;
  localparam logic [6:0] CODE_ANO   = 7'h26;
  localparam logic [6:0] CODE_SEGT  = 7'h41;
  localparam logic [6:0] CODE_MINT  = 7'h42;
  localparam logic [6:0] CODE_HORAT = 7'h43;

  localparam logic [7:0] BCD_00 = 8'h00;
  localparam logic [7:0] BCD_01 = 8'h01;
  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_31 = 8'h31;
  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_99 = 8'h99;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_ADJUST = 2'd2,
    ST_WRITE  = 2'd3
  } edit_state_e;

  // Winning button after priority resolution; at most one acts per cycle.
  typedef enum logic [2:0] {
    WIN_NONE = 3'd0,
    WIN_EDIT = 3'd1,
    WIN_UP   = 3'd2,
    WIN_DN   = 3'd3,
    WIN_R    = 3'd4,
    WIN_L    = 3'd5
  } btn_win_e;

  function automatic logic [6:0] field_code(input logic [3:0] idx);
    case (idx)
      4'd0:    return CODE_SEG;
      4'd1:    return CODE_MIN;
      4'd2:    return CODE_HORA;
      4'd3:    return CODE_DIA;
      4'd4:    return CODE_MES;
      4'd5:    return CODE_ANO;
      4'd6:    return CODE_SEGT;
      4'd7:    return CODE_MINT;
      4'd8:    return CODE_HORAT;
      default: return CODE_NONE;
    endcase
  endfunction

  function automatic logic [7:0] field_min(input logic [3:0] idx);
    case (idx)
      4'd3, 4'd4: return BCD_01;
      default:    return BCD_00;
    endcase
  endfunction

  function automatic logic [7:0] field_max(input logic [3:0] idx);
    case (idx)
      4'd2, 4'd8: return BCD_23;
      4'd3:       return BCD_31;
      4'd4:       return BCD_12;
      4'd5:       return BCD_99;
      default:    return BCD_59;
    endcase
  endfunction

  function automatic logic [3:0] idx_next(input logic [3:0] idx);
    return (idx >= IDX_LAST) ? IDX_FIRST : idx + 4'd1;
  endfunction

  function automatic logic [3:0] idx_prev(input logic [3:0] idx);
    return (idx == IDX_FIRST || idx > IDX_LAST) ? IDX_LAST : idx - 4'd1;
  endfunction

endpackage

// File: rtl/bcd_step.sv
// rtl/bcd_step.sv - one-unit BCD increment/decrement with range wrap; invalid
// inputs snap to the range min (up) or max (down).
module bcd_step (
  input  logic [7:0] value_i,
  input  logic [7:0] min_i,
  input  logic [7:0] max_i,
  input  logic       up_i,
  input  logic       dn_i,
  output logic [7:0] next_o
);

  logic [3:0] hi;
  logic [3:0] lo;
  logic       is_bcd;
  logic       in_range;
  logic       valid;

  always_comb begin
    hi       = value_i[7:4];
    lo       = value_i[3:0];
    is_bcd   = (hi <= 4'd9) && (lo <= 4'd9);
    // For well-formed BCD bytes a plain binary compare orders them correctly.
    in_range = (value_i >= min_i) && (value_i <= max_i);
    valid    = is_bcd && in_range;
    next_o   = value_i;
    if (up_i) begin
      if (!valid || value_i == max_i) begin
        next_o = min_i;
      end else if (lo == 4'd9) begin
        next_o = {hi + 4'd1, 4'd0};
      end else begin
        next_o = {hi, lo + 4'd1};
      end
    end else if (dn_i) begin
      if (!valid || value_i == min_i) begin
        next_o = max_i;
      end else if (lo == 4'd0) begin
        next_o = {hi - 4'd1, 4'd9};
      end else begin
        next_o = {hi, lo - 4'd1};
      end
    end
  end

endmodule

// File: rtl/edit_cursor_ctrl.sv
// rtl/edit_cursor_ctrl.sv - button-driven RTC field editor: select a field,
// adjust a BCD shadow copy, then issue a single write to the RTC.
module edit_cursor_ctrl
  import rtc_edit_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_UP,
  input  logic       BTN_DN,
  input  logic       BTN_L,
  input  logic       BTN_R,
  input  logic       BTN_EDIT,
  input  logic [7:0] SEG_T,
  input  logic [7:0] MIN_T,
  input  logic [7:0] HORA_T,
  input  logic [7:0] DIA_T,
  input  logic [7:0] MES_T,
  input  logic [7:0] ANO_T,
  input  logic [7:0] SEGT_T,
  input  logic [7:0] MINT_T,
  input  logic [7:0] HORAT_T,
  input  logic       WR_ACK,
  output logic [6:0] Puntero,
  output logic       WR_REQ,
  output logic [7:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  output logic       EDIT_ACTIVE
);

  edit_state_e state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  shadow_q, shadow_d;
  logic [31:0] cnt_q, cnt_d;
  logic [6:0]  punt_q, punt_d;
  logic        wr_req_q, wr_req_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        active_q, active_d;

  btn_win_e    win;
  logic [7:0]  rtc_sel;
  logic [7:0]  fmin;
  logic [7:0]  fmax;
  logic [7:0]  step_next;
  logic        cnt_clr;
  logic        timeout_hit;

  always_comb begin
    win = WIN_NONE;
    if (BTN_EDIT)    win = WIN_EDIT;
    else if (BTN_UP) win = WIN_UP;
    else if (BTN_DN) win = WIN_DN;
    else if (BTN_R)  win = WIN_R;
    else if (BTN_L)  win = WIN_L;
  end

  always_comb begin
    case (idx_q)
      4'd0:    rtc_sel = SEG_T;
      4'd1:    rtc_sel = MIN_T;
      4'd2:    rtc_sel = HORA_T;
      4'd3:    rtc_sel = DIA_T;
      4'd4:    rtc_sel = MES_T;
      4'd5:    rtc_sel = ANO_T;
      4'd6:    rtc_sel = SEGT_T;
      4'd7:    rtc_sel = MINT_T;
      4'd8:    rtc_sel = HORAT_T;
      default: rtc_sel = BCD_00;
    endcase
  end

  assign fmin = field_min(idx_q);
  assign fmax = field_max(idx_q);

  bcd_step u_bcd_step (
    .value_i (shadow_q),
    .min_i   (fmin),
    .max_i   (fmax),
    .up_i    (win == WIN_UP),
    .dn_i    (win == WIN_DN),
    .next_o  (step_next)
  );

  assign cnt_clr     = (win != WIN_NONE) || WR_ACK;
  assign timeout_hit = !cnt_clr && (cnt_q == TIMEOUT_CYC - 32'd1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    cnt_d     = cnt_q;
    wr_req_d  = wr_req_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (win == WIN_EDIT) begin
          state_d = ST_SELECT;
          idx_d   = IDX_FIRST;
        end
      end

      ST_SELECT: begin
        cnt_d = cnt_clr ? '0 : cnt_q + 32'd1;
        if (timeout_hit) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          shadow_d = BCD_00;
        end else begin
          case (win)
            WIN_EDIT: begin
              state_d  = ST_ADJUST;
              shadow_d = rtc_sel;
            end
            WIN_R:   idx_d = idx_next(idx_q);
            WIN_L:   idx_d = idx_prev(idx_q);
            default: ;
          endcase
        end
      end

      ST_ADJUST: begin
        cnt_d = cnt_clr ? '0 : cnt_q + 32'd1;
        if (timeout_hit) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          shadow_d = BCD_00;
        end else begin
          case (win)
            WIN_EDIT: begin
              state_d   = ST_WRITE;
              wr_req_d  = 1'b1;
              wr_addr_d = {1'b0, field_code(idx_q)};
              wr_data_d = shadow_q;
            end
            WIN_UP, WIN_DN: shadow_d = step_next;
            default: ;
          endcase
        end
      end

      ST_WRITE: begin
        // The write is never abandoned; only the bus acknowledge ends it.
        cnt_d = '0;
        if (WR_ACK) begin
          state_d  = ST_SELECT;
          wr_req_d = 1'b0;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        wr_req_d = 1'b0;
        cnt_d    = '0;
      end
    endcase

    punt_d   = (state_d == ST_IDLE) ? CODE_NONE : field_code(idx_d);
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      idx_q     <= IDX_FIRST;
      shadow_q  <= BCD_00;
      cnt_q     <= '0;
      punt_q    <= CODE_NONE;
      wr_req_q  <= 1'b0;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      punt_q    <= punt_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      active_q  <= active_d;
    end
  end

  assign Puntero     = punt_q;
  assign WR_REQ      = wr_req_q;
  assign WR_ADDR     = wr_addr_q;
  assign WR_DATA     = wr_data_q;
  assign EDIT_ACTIVE = active_q;

endmodule

// File: tb/tb_edit_cursor_ctrl.sv
// tb/tb_edit_cursor_ctrl.sv - directed and randomized checks of edit_cursor_ctrl
// against a field/decimal-level reference model.
module tb_edit_cursor_ctrl;

  localparam logic [31:0] TO = 32'd16;
  localparam int M_IDLE = 0;
  localparam int M_SEL  = 1;
  localparam int M_ADJ  = 2;
  localparam int M_WR   = 3;

  logic       CLK;
  logic       RST;
  logic       BTN_UP, BTN_DN, BTN_L, BTN_R, BTN_EDIT;
  logic [7:0] rtc [9];
  logic       WR_ACK;
  logic [6:0] Puntero;
  logic       WR_REQ;
  logic [7:0] WR_ADDR, WR_DATA;
  logic       EDIT_ACTIVE;

  int codes  [9] = '{'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h41, 'h42, 'h43};
  int lo_lim [9] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
  int hi_lim [9] = '{59, 59, 23, 31, 12, 99, 59, 59, 23};
  int exp_seq[10] = '{'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h41, 'h42, 'h43, 'h21};

  int         m_st, m_idx, m_quiet;
  logic [7:0] m_sh, m_addr, m_data;
  logic       m_req;
  int         n_pass, n_total;

  edit_cursor_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RST(RST),
    .BTN_UP(BTN_UP), .BTN_DN(BTN_DN), .BTN_L(BTN_L), .BTN_R(BTN_R), .BTN_EDIT(BTN_EDIT),
    .SEG_T(rtc[0]), .MIN_T(rtc[1]), .HORA_T(rtc[2]), .DIA_T(rtc[3]), .MES_T(rtc[4]),
    .ANO_T(rtc[5]), .SEGT_T(rtc[6]), .MINT_T(rtc[7]), .HORAT_T(rtc[8]),
    .WR_ACK(WR_ACK), .Puntero(Puntero), .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA), .EDIT_ACTIVE(EDIT_ACTIVE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] to_bcd(input int d);
    return 8'((d / 10) * 16 + (d % 10));
  endfunction

  function automatic logic [7:0] model_step(input logic [7:0] v, input int f, input bit up);
    int hi, lo, d;
    bit ok;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    d  = hi * 10 + lo;
    ok = (hi < 10) && (lo < 10) && (d >= lo_lim[f]) && (d <= hi_lim[f]);
    if (up) return (!ok || d == hi_lim[f]) ? to_bcd(lo_lim[f]) : to_bcd(d + 1);
    return (!ok || d == lo_lim[f]) ? to_bcd(hi_lim[f]) : to_bcd(d - 1);
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_idx = 0; m_quiet = 0;
    m_sh = 8'h00; m_addr = 8'h00; m_data = 8'h00; m_req = 1'b0;
  endtask

  task automatic model_clock(input bit e, u, d, l, r, ack);
    bit any;
    any = e | u | d | l | r;
    case (m_st)
      M_IDLE: if (e) begin m_st = M_SEL; m_idx = 0; end
      M_SEL, M_ADJ: begin
        if (!any && !ack) begin
          if (m_quiet == int'(TO) - 1) begin m_st = M_IDLE; m_quiet = 0; end
          else m_quiet++;
        end else begin
          m_quiet = 0;
          if (m_st == M_SEL) begin
            if (e) begin m_st = M_ADJ; m_sh = rtc[m_idx]; end
            else if (u || d) ;
            else if (r) m_idx = (m_idx + 1) % 9;
            else if (l) m_idx = (m_idx + 8) % 9;
          end else begin
            if (e) begin
              m_st = M_WR; m_req = 1'b1; m_addr = 8'(codes[m_idx]); m_data = m_sh;
            end
            else if (u) m_sh = model_step(m_sh, m_idx, 1'b1);
            else if (d) m_sh = model_step(m_sh, m_idx, 1'b0);
          end
        end
      end
      default: if (ack) begin m_st = M_SEL; m_req = 1'b0; m_quiet = 0; end
    endcase
  endtask

  task automatic check_all();
    chk("puntero", 32'(Puntero), (m_st == M_IDLE) ? 32'h0 : 32'(codes[m_idx]));
    chk("edit_active", 32'(EDIT_ACTIVE), 32'(m_st != M_IDLE));
    chk("wr_req", 32'(WR_REQ), 32'(m_req));
    chk("wr_addr", 32'(WR_ADDR), 32'(m_addr));
    chk("wr_data", 32'(WR_DATA), 32'(m_data));
  endtask

  task automatic cyc(input bit e, u, d, l, r, ack);
    BTN_EDIT = e; BTN_UP = u; BTN_DN = d; BTN_L = l; BTN_R = r; WR_ACK = ack;
    @(posedge CLK);
    #1;
    model_clock(e, u, d, l, r, ack);
    BTN_EDIT = 0; BTN_UP = 0; BTN_DN = 0; BTN_L = 0; BTN_R = 0; WR_ACK = 0;
    check_all();
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    RST = 1'b0;
    BTN_EDIT = 0; BTN_UP = 0; BTN_DN = 0; BTN_L = 0; BTN_R = 0; WR_ACK = 0;
    for (int i = 0; i < 9; i++) rtc[i] = 8'h00;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_puntero", 32'(Puntero), 32'h00);
    chk("rst_wr_req", 32'(WR_REQ), 32'h0);
    chk("rst_wr_addr", 32'(WR_ADDR), 32'h00);
    chk("rst_wr_data", 32'(WR_DATA), 32'h00);
    chk("rst_active", 32'(EDIT_ACTIVE), 32'h0);
    RST = 1'b1;

    // Field ring walk
    cyc(1, 0, 0, 0, 0, 0);
    chk("ring_start", 32'(Puntero), 32'h21);
    for (int i = 1; i < 10; i++) begin
      cyc(0, 0, 0, 0, 1, 0);
      chk("ring_step", 32'(Puntero), 32'(exp_seq[i]));
    end
    cyc(0, 0, 0, 1, 0, 0);
    chk("ring_left_wrap", 32'(Puntero), 32'h43);
    cyc(0, 0, 0, 0, 1, 0);

    // Minutes 59 -> 00 and write handshake
    cyc(0, 0, 0, 0, 1, 0);
    rtc[1] = 8'h59;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("adj_ignores_l", 32'(Puntero), 32'h22);
    cyc(1, 0, 0, 0, 0, 0);
    chk("wr_req_min", 32'(WR_REQ), 32'h1);
    chk("wr_addr_min", 32'(WR_ADDR), 32'h22);
    chk("wr_data_min", 32'(WR_DATA), 32'h00);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 1, 0);
      chk("wr_req_hold", 32'(WR_REQ), 32'h1);
    end
    cyc(0, 0, 0, 0, 0, 1);
    chk("wr_req_drop", 32'(WR_REQ), 32'h0);
    chk("after_wr_select", 32'(Puntero), 32'h22);

    // Day 01 -> 31 and month 00 -> 01
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    rtc[3] = 8'h01;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("dia_wrap_dn", 32'(WR_DATA), 32'h31);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0);
    rtc[4] = 8'h00;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("mes_invalid_up", 32'(WR_DATA), 32'h01);
    cyc(0, 0, 0, 0, 0, 1);

    // EDIT beats UP in ADJUST
    rtc[4] = 8'h07;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("edit_prio_req", 32'(WR_REQ), 32'h1);
    chk("edit_prio_data", 32'(WR_DATA), 32'h07);
    cyc(0, 0, 0, 0, 0, 1);

    // Timeout from ADJUST
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("to_no_write", 32'(WR_REQ), 32'h0);
    end
    chk("to_not_yet", 32'(EDIT_ACTIVE), 32'h1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("to_puntero", 32'(Puntero), 32'h00);
    chk("to_active", 32'(EDIT_ACTIVE), 32'h0);
    chk("to_no_write_end", 32'(WR_REQ), 32'h0);

    // Asynchronous reset during WRITE
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("pre_rst_req", 32'(WR_REQ), 32'h1);
    #2;
    RST = 1'b0;
    #1;
    chk("async_rst_req", 32'(WR_REQ), 32'h0);
    chk("async_rst_punt", 32'(Puntero), 32'h00);
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    chk("post_rst_punt", 32'(Puntero), 32'h00);
    chk("post_rst_noretry", 32'(WR_REQ), 32'h0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      bit e, u, d, l, r, ack;
      if ($urandom_range(0, 7) == 0) begin
        int k;
        k = int'($urandom_range(0, 8));
        rtc[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                             : to_bcd(int'($urandom_range(lo_lim[k], hi_lim[k])));
      end
      if ($urandom_range(0, 59) == 0) begin
        for (int q = 0; q < 17; q++) cyc(0, 0, 0, 0, 0, 0);
      end
      e   = ($urandom_range(0, 7) == 0);
      u   = ($urandom_range(0, 4) == 0);
      d   = ($urandom_range(0, 4) == 0);
      l   = ($urandom_range(0, 5) == 0);
      r   = ($urandom_range(0, 5) == 0);
      ack = (m_st == M_WR) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      cyc(e, u, d, l, r, ack);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
